// File: rtl/lvds_video_timing_gen_if.sv
// Pixel stream carried from an upstream frame source (master) into the
// video timing generator (slave).
interface lvds_video_timing_gen_if;
    logic        pix_valid;
    logic [23:0] pix_data;
    logic        pix_ready;

    modport master (output pix_valid, output pix_data, input pix_ready);
    modport slave  (input pix_valid, input pix_data, output pix_ready);
endinterface

// File: rtl/lvds_video_timing_gen.sv
// Raster timing and pixel source feeding the LVDS transmitter: generates
// HSync/VSync/Blank and 8:8:8 RGB from an external stream or a test pattern.
module lvds_video_timing_gen #(
    parameter int H_ACTIVE    = 1024,
    parameter int H_FP        = 24,
    parameter int H_SYNC      = 136,
    parameter int H_BP        = 160,
    parameter int V_ACTIVE    = 768,
    parameter int V_FP        = 3,
    parameter int V_SYNC      = 6,
    parameter int V_BP        = 29,
    parameter bit HS_POL      = 1'b0,
    parameter bit VS_POL      = 1'b0,
    parameter bit BLANK_IS_DE = 1'b1
) (
    input  logic                   Video_Clock,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic [1:0]             pattern_sel,
    lvds_video_timing_gen_if.slave pix_if,
    output logic                   Video_HSync,
    output logic                   Video_VSync,
    output logic                   Video_Blank,
    output logic [7:0]             Video_Red,
    output logic [7:0]             Video_Green,
    output logic [7:0]             Video_Blue,
    output logic                   frame_start,
    output logic                   underflow,
    input  logic                   underflow_clr
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW       = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VW       = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam int BAR_W    = H_ACTIVE / 8;
    localparam int BW       = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam logic HS_IDLE    = ~HS_POL;
    localparam logic VS_IDLE    = ~VS_POL;
    localparam logic BLANK_IDLE = ~BLANK_IS_DE;

    localparam logic [23:0] BAR_RGB [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic [BW-1:0] bar_pix_q, bar_pix_d;
    logic [2:0]    bar_idx_q, bar_idx_d;
    logic [1:0]    pattern_q, pattern_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          blank_q, blank_d;
    logic [23:0]   rgb_q, rgb_d;
    logic          frame_start_q, frame_start_d;
    logic          underflow_q, underflow_d;

    logic [31:0]   h_ext;
    logic [31:0]   v_ext;
    logic          active_h;
    logic          active;
    logic          hs_region;
    logic          vs_region;
    logic          h_last;
    logic          v_last;
    logic          at_origin;
    logic [1:0]    pattern_cur;
    logic          run_go;
    logic          pix_ready_c;
    logic          starve;
    logic [23:0]   src_rgb;

    assign h_ext     = 32'(h_cnt_q);
    assign v_ext     = 32'(v_cnt_q);
    assign active_h  = (h_ext < H_ACTIVE);
    assign active    = active_h && (v_ext < V_ACTIVE);
    assign hs_region = (h_ext >= HS_START) && (h_ext < HS_END);
    assign vs_region = (v_ext >= VS_START) && (v_ext < VS_END);
    assign h_last    = (h_ext == H_TOTAL - 1);
    assign v_last    = (v_ext == V_TOTAL - 1);
    assign at_origin = (h_cnt_q == '0) && (v_cnt_q == '0);

    // The pattern for a whole frame is taken at pixel (0,0), so that pixel
    // already uses the freshly sampled selection.
    assign pattern_cur = at_origin ? pattern_sel : pattern_q;

    // Gating with enable and reset_n keeps a word from being consumed on a
    // cycle whose pixel will never reach the outputs.
    assign run_go      = reset_n && (state_q == ST_RUN) && enable;
    assign pix_ready_c = run_go && active && (pattern_cur == 2'd0);
    assign starve      = pix_ready_c && !pix_if.pix_valid;

    assign pix_if.pix_ready = pix_ready_c;

    always_comb begin
        src_rgb = 24'h000000;
        case (pattern_cur)
            2'd0:    src_rgb = pix_if.pix_valid ? pix_if.pix_data : 24'h000000;
            2'd1:    src_rgb = BAR_RGB[bar_idx_q];
            2'd2:    src_rgb = {3{h_ext[7:0]}};
            default: src_rgb = 24'h0000FF;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        h_cnt_d       = '0;
        v_cnt_d       = '0;
        bar_pix_d     = '0;
        bar_idx_d     = '0;
        pattern_d     = pattern_q;
        hsync_d       = HS_IDLE;
        vsync_d       = VS_IDLE;
        blank_d       = BLANK_IDLE;
        rgb_d         = 24'h000000;
        frame_start_d = 1'b0;

        underflow_d = underflow_q;
        if (underflow_clr) begin
            underflow_d = 1'b0;
        end
        if (starve) begin
            underflow_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d   = ST_RUN;
                    pattern_d = pattern_sel;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else begin
                    pattern_d = pattern_cur;
                    if (h_last) begin
                        h_cnt_d = '0;
                        v_cnt_d = v_last ? '0 : v_cnt_q + VW'(1);
                    end else begin
                        h_cnt_d   = h_cnt_q + HW'(1);
                        v_cnt_d   = v_cnt_q;
                        bar_pix_d = bar_pix_q;
                        bar_idx_d = bar_idx_q;
                        // Bar position tracks h_cnt by counting, avoiding a divider.
                        if (active_h) begin
                            if (bar_pix_q == BW'(BAR_W - 1)) begin
                                bar_pix_d = '0;
                                bar_idx_d = bar_idx_q + 3'd1;
                            end else begin
                                bar_pix_d = bar_pix_q + BW'(1);
                            end
                        end
                    end

                    hsync_d       = hs_region ? ~HS_IDLE : HS_IDLE;
                    vsync_d       = vs_region ? ~VS_IDLE : VS_IDLE;
                    blank_d       = active ? ~BLANK_IDLE : BLANK_IDLE;
                    rgb_d         = active ? src_rgb : 24'h000000;
                    frame_start_d = at_origin;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Video_Clock) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            bar_pix_q     <= '0;
            bar_idx_q     <= '0;
            pattern_q     <= 2'd0;
            hsync_q       <= HS_IDLE;
            vsync_q       <= VS_IDLE;
            blank_q       <= BLANK_IDLE;
            rgb_q         <= 24'h000000;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            bar_pix_q     <= bar_pix_d;
            bar_idx_q     <= bar_idx_d;
            pattern_q     <= pattern_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            blank_q       <= blank_d;
            rgb_q         <= rgb_d;
            frame_start_q <= frame_start_d;
            underflow_q   <= underflow_d;
        end
    end

    assign Video_HSync = hsync_q;
    assign Video_VSync = vsync_q;
    assign Video_Blank = blank_q;
    assign Video_Red   = rgb_q[23:16];
    assign Video_Green = rgb_q[15:8];
    assign Video_Blue  = rgb_q[7:0];
    assign frame_start = frame_start_q;
    assign underflow   = underflow_q;

endmodule

// File: doc/lvds_video_timing_gen.md
# lvds_video_timing_gen

Video timing and pixel-source stage that sits directly upstream of the LVDS transmitter in the `Video_Clock` domain. It generates the Video_HSync/Video_VSync/Video_Blank raster and the 8:8:8 RGB bus from an external pixel stream or from an internal test pattern. It also flags stream underflow and marks frame starts for the rest of the display path.

## Interface

Parameters:
- H_ACTIVE, 1024, active pixels per line; must be a multiple of 8.
- H_FP, 24, horizontal front porch, in pixels.
- H_SYNC, 136, horizontal sync width, in pixels.
- H_BP, 160, horizontal back porch, in pixels.
- V_ACTIVE, 768, active lines per frame.
- V_FP, 3, vertical front porch, in lines.
- V_SYNC, 6, vertical sync width, in lines.
- V_BP, 29, vertical back porch, in lines.
- HS_POL, 0, HSync asserted level.
- VS_POL, 0, VSync asserted level.
- BLANK_IS_DE, 1.
  - 1: Video_Blank=1 on active pixels (data-enable semantics, as carried on the LVDS control bit).
  - 0: Video_Blank=1 during blanking.

Ports:
- Video_Clock  in  1  pixel clock; the only clock.
- reset_n  in  1  synchronous, active-low reset.
- enable  in  1  run raster; 0 forces idle.
- pattern_sel  in  2  0 external stream, 1 colour bars, 2 grey ramp, 3 solid blue.
- pix_valid  in  1  external pixel available.
- pix_data  in  24  {R[7:0],G[7:0],B[7:0]}.
- pix_ready  out  1  pixel consumed this cycle when pix_valid=1.
- Video_HSync  out  1  horizontal sync.
- Video_VSync  out  1  vertical sync.
- Video_Blank  out  1  blank/DE according to BLANK_IS_DE.
- Video_Red  out  8  red component.
- Video_Green  out  8  green component.
- Video_Blue  out  8  blue component.
- frame_start  out  1  one-cycle pulse coincident with output of pixel (0,0).
- underflow  out  1  sticky flag: stream starved in an active pixel.
- underflow_clr  in  1  clears underflow.

## Operation

- Counters:
  - h_cnt runs 0..H_TOTAL-1, where H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP.
  - v_cnt runs 0..V_TOTAL-1 and increments when h_cnt wraps.
  - Counter widths are $clog2 of the respective totals; both totals must be ≤4096.
  - Both counters wrap to 0 at their terminal value.
- Region decode, combinational from the counters:
  - active = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
  - hs = H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vs = V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC. vs changes only at h_cnt=0.
- States: IDLE and RUN.
  - IDLE → RUN when enable=1. The first RUN cycle has h_cnt=v_cnt=0.
  - RUN → IDLE on the first cycle enable=0. Counters are cleared to 0.
  - In IDLE, all outputs are held at their reset values.
- Pattern selection: the active pattern register loads from pattern_sel only when h_cnt=0 and v_cnt=0 in RUN, and on the IDLE→RUN transition. A mid-frame change never tears a frame.
- Pixel source during active cycles:
  - Mode 0:
    - pix_ready=1.
    - If pix_valid=1, pix_data is output.
    - If pix_valid=0, 0x000000 is output and underflow sets.
  - Mode 1 (colour bars): bar width H_ACTIVE/8, tracked by a bar counter with no divider. Left to right: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - Mode 2 (grey ramp): R=G=B=h_cnt[7:0].
  - Mode 3 (solid blue): 0x0000FF.
- pix_ready is 0 outside active cycles, in modes 1–3, and in IDLE.
- Blanking: RGB outputs are 0x000000 whenever the pixel is not active.
- underflow:
  - Set has priority over underflow_clr in the same cycle.
  - Reset clears it. IDLE does not clear it.

## Timing

- pix_ready is combinational from the counter state in the same cycle. The handshake completes on a Video_Clock edge with pix_valid&&pix_ready.
- All video outputs and frame_start are registered: one cycle of latency from counter state to outputs. Sync, blank and RGB stay mutually aligned.
- Reset values, also the IDLE values:
  - Video_HSync=~HS_POL.
  - Video_VSync=~VS_POL.
  - Video_Blank=0 if BLANK_IS_DE, else 1.
  - RGB=0.
  - frame_start=0.
  - underflow=0.
  - pix_ready=0.
- Reset applied mid-frame returns to IDLE on the next edge. The pattern register resets to 0.
- Enable rising at edge n gives first-pixel outputs after edge n+2: state enters RUN at edge n+1 and outputs register at n+2.

## Test plan

Small configuration for all scenarios: H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2 (H_TOTAL=14); V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1 (V_TOTAL=7); HS_POL=VS_POL=0; BLANK_IS_DE=1.

1. Reset/idle: reset_n=0 for 3 cycles, then enable=0 → HSync=1, VSync=1, Blank=0, RGB=0, pix_ready=0 indefinitely. Then enable=1 → frame_start pulses exactly 2 cycles later.
2. Raster, pattern 1:
   - HSync is low for 2 cycles, every 14 cycles, starting 10 cycles after frame_start.
   - Blank=1 for 8 cycles per line on 4 lines per frame.
   - VSync is low for 14 cycles starting 70 cycles after frame_start.
   - frame_start period is 98.
3. Colour bars → line pixels FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000, then 0 during blanking.
4. Mode 0 with pix_valid=1 and pix_data incrementing from 0x000001 → exactly 32 handshakes per frame. Output pixel k equals word k one cycle after its handshake. underflow stays 0.
5. Mode 0 with pix_valid=0 on line 0 pixel 3 only → that pixel outputs 000000 and underflow=1 holds until underflow_clr. Pixel 4 outputs the word that was pending at pixel 3. Asserting set and clr in the same cycle leaves underflow=1.
6. Change pattern_sel 1→2 mid-frame → the current frame completes as bars and the ramp starts at the next frame_start. Drop enable at h_cnt=5 → idle outputs one cycle later. Re-enable → restarts at (0,0).
